tff: RTL and testbench

//   Parameterised toggle (T) flip-flop bank, default 1 bit wide.

---
 rtl/tff.sv | 21 ++
 tb/tb_tff.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tff.sv
// Bank of WIDTH independent toggle flip-flops with synchronous active-low reset.
// Used as the state-bit storage of small FSMs that build their T excitation combinationally.
module tff #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             res
);

    // Reset has priority over t; bits toggle independently (no carry between bits).
    always_ff @(posedge clk) begin
        if (!res)
            q <= RESET_VAL;
        else
            q <= q ^ t;
    end

endmodule

// File: tb/tb_tff.sv
// Scoreboard bench for tff: a 1-bit bank, a 4-bit bank with a non-zero reset value,
// and a two-bit FSM built from two 1-bit instances.
module tb_tff;

    logic       clk = 1'b0;
    logic       res;
    logic       t1;
    logic       q1;
    logic [3:0] t4;
    logic [3:0] q4;
    logic       x;
    logic       fa, fb;
    logic       ta, tb;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [3:0] RV4 = 4'b1010;

    always #5 clk = ~clk;

    tff dut1 (.q(q1), .t(t1), .clk(clk), .res(res));
    tff #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (.q(q4), .t(t4), .clk(clk), .res(res));
    tff dut_a (.q(fa), .t(ta), .clk(clk), .res(res));
    tff dut_b (.q(fb), .t(tb), .clk(clk), .res(res));

    assign ta = ~x & fb;
    assign tb = (~x & ~fb) | (~x & fa) | (x & ~fa & fb);

    typedef struct {
        string      tag;
        logic       q1;
        logic [3:0] q4;
        logic [1:0] ab;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic       m1;
    logic [3:0] m4;
    logic       ma, mb;
    bit         model_valid = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, predict, then compare after the rising edge.
    // glitch pulses res and t to their opposite values well between edges.
    task automatic step(input string tag, input logic r, input logic tv1,
                        input logic [3:0] tv4, input logic xv, input bit glitch);
        exp_t e;
        logic nta, ntb;
        @(negedge clk);
        res = r; t1 = tv1; t4 = tv4; x = xv;
        nta = ~xv & mb;
        ntb = (~xv & ~mb) | (~xv & ma) | (xv & ~ma & mb);
        e.tag = tag;
        e.q1  = r ? (m1 ^ tv1) : 1'b0;
        e.q4  = r ? (m4 ^ tv4) : RV4;
        e.ab  = r ? {ma ^ nta, mb ^ ntb} : 2'b00;
        sb.push_back(e);
        if (glitch) begin
            #1 res = ~r; t1 = ~tv1; t4 = ~tv4;
            #2 res = r;  t1 = tv1;  t4 = tv4;
            #1;
        end else begin
            #4;
        end
        if (model_valid) begin
            check({tag, "_pre_q1"}, {7'd0, q1}, {7'd0, m1});
            check({tag, "_pre_q4"}, {4'd0, q4}, {4'd0, m4});
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_q1"}, {7'd0, q1}, {7'd0, e.q1});
        check({e.tag, "_q4"}, {4'd0, q4}, {4'd0, e.q4});
        check({e.tag, "_ab"}, {6'd0, fa, fb}, {6'd0, e.ab});
        m1 = e.q1; m4 = e.q4; {ma, mb} = e.ab;
        model_valid = 1;
    endtask

    initial begin
        logic       eq1 [4];
        logic [1:0] eab [4];
        res = 1'b1; t1 = 1'b0; t4 = '0; x = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with t high
        step("reset", 1'b0, 1'b1, 4'hF, 1'b0, 0);
        check("reset_const_q1", {7'd0, q1}, 8'd0);
        check("reset_const_q4", {4'd0, q4}, {4'd0, RV4});

        // Toggle four edges; the given T equations cycle 00->01->11->00->01
        eq1 = '{1'b1, 1'b0, 1'b1, 1'b0};
        eab = '{2'b01, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            step("toggle", 1'b1, 1'b1, 4'b0110, 1'b0, 0);
            check("toggle_const_q1", {7'd0, q1}, {7'd0, eq1[i]});
            check("fsm_const_ab", {6'd0, fa, fb}, {6'd0, eab[i]});
        end

        // Bring q1 to 1; x=1 from AB=01 goes to 00
        step("x1", 1'b1, 1'b1, 4'b0001, 1'b1, 0);
        check("fsm_x1_ab", {6'd0, fa, fb}, 8'd0);

        // Hold with t glitches and res glitches between edges
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b0, 4'b0000, 1'b1, 1);
            check("hold_const_q1", {7'd0, q1}, 8'd1);
        end

        // Sync reset taken at the edge only
        step("sync_rst", 1'b0, 1'b0, 4'b0000, 1'b0, 0);
        check("sync_rst_const_q1", {7'd0, q1}, 8'd0);

        // Priority: reset wins over t with q1=1
        step("set1", 1'b1, 1'b1, 4'b1111, 1'b0, 0);
        step("prio", 1'b0, 1'b1, 4'b1111, 1'b0, 0);
        check("prio_const_q1", {7'd0, q1}, 8'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom),
                 1'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
